// File: rtl/fetch_sequencer_if.sv
// Bus between the fetch sequencer and its neighbours: control inputs,
// the ins_fetch address/return path and the valid/ready output stream.
interface fetch_sequencer_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [XLEN-1:0] base_cfg;
  logic            halt;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic [XLEN-1:0] pc_out;
  logic [XLEN-1:0] base_out;
  logic [XLEN-1:0] ins_in;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_ins;
  logic            busy;

  // Sequencer side
  modport master (
    input  start, base_cfg, halt, redirect_valid, redirect_pc, ins_in, out_ready,
    output pc_out, base_out, out_valid, out_pc, out_ins, busy
  );

  // Environment side (fetch datapath, controller and consumer)
  modport slave (
    output start, base_cfg, halt, redirect_valid, redirect_pc, ins_in, out_ready,
    input  pc_out, base_out, out_valid, out_pc, out_ins, busy
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: issues word-index PCs to the instruction fetch datapath,
// tracks fetches across a fixed latency, and queues {pc, instruction} pairs
// for the execute stage. Redirect flushes via an epoch bit; halt drains.
//
// state    | meaning
// ---------+------------------------------------------------------
// ST_IDLE  | waiting for start; pc_out/base_out hold
// ST_RUN   | issuing one fetch per cycle while credits allow
// ST_DRAIN | no issue; wait for in-flight fetches and FIFO to empty
module fetch_sequencer #(
  parameter int              XLEN      = 32,
  parameter int              FETCH_LAT = 2,
  parameter int              Q_DEPTH   = 4,
  parameter logic [XLEN-1:0] START_PC  = '0
) (
  input logic               clk,
  input logic               rst,
  fetch_sequencer_if.master bus
);

  localparam int AW = $clog2(Q_DEPTH);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam logic [AW+1:0] DEPTH_W = (AW + 2)'(Q_DEPTH);

  logic [1:0]           r_state;
  logic [XLEN-1:0]      r_pc;
  logic [XLEN-1:0]      r_base;
  logic                 r_epoch;
  logic [AW:0]          r_inflight;

  logic [FETCH_LAT-1:0] r_pipe_vld;
  logic [FETCH_LAT-1:0] r_pipe_tag;
  logic [XLEN-1:0]      r_pipe_pc [FETCH_LAT];

  logic [XLEN-1:0]      r_fifo_pc  [Q_DEPTH];
  logic [XLEN-1:0]      r_fifo_ins [Q_DEPTH];
  logic [AW-1:0]        r_wptr;
  logic [AW-1:0]        r_rptr;
  logic [AW:0]          r_count;

  logic                 w_flush;
  logic [AW+1:0]        w_used;
  logic                 w_credit;
  logic                 w_issue;
  logic                 w_ret;
  logic                 w_push;
  logic                 w_pop;

  // A redirect only matters once fetching has started.
  assign w_flush  = bus.redirect_valid && (r_state != ST_IDLE);

  // Outstanding fetches plus queued entries may never exceed the FIFO depth,
  // so every return is guaranteed a slot. A pop this cycle frees credit next cycle.
  assign w_used   = {1'b0, r_inflight} + {1'b0, r_count};
  assign w_credit = (w_used < DEPTH_W);

  assign w_issue  = (r_state == ST_RUN) && !bus.halt && !bus.redirect_valid && w_credit;

  // Oldest pipe stage lines up with the cycle ins_in carries its instruction.
  assign w_ret    = r_pipe_vld[FETCH_LAT-1];
  assign w_push   = w_ret && (r_pipe_tag[FETCH_LAT-1] == r_epoch) && !w_flush;
  assign w_pop    = (r_count != '0) && bus.out_ready;

  // Control FSM, PC generation and base latch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_pc    <= START_PC;
      r_base  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_state <= ST_RUN;
            r_base  <= bus.base_cfg;
            r_pc    <= START_PC;
          end
        end
        ST_RUN: begin
          if (bus.redirect_valid) begin
            r_pc <= bus.redirect_pc;
          end else if (w_issue) begin
            r_pc <= r_pc + 1'b1;
          end
          if (bus.halt) begin
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if ((r_inflight == '0) && (r_count == '0)) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Epoch flips on every accepted redirect; older fetches then mismatch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_epoch <= 1'b0;
    end else if (w_flush) begin
      r_epoch <= ~r_epoch;
    end
  end

  // In-flight counter: stale returns still release their credit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inflight <= '0;
    end else begin
      case ({w_issue, w_ret})
        2'b10:   r_inflight <= r_inflight + 1'b1;
        2'b01:   r_inflight <= r_inflight - 1'b1;
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  // Latency pipe: valid/epoch tag/pc of each issued fetch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pipe_vld <= '0;
      r_pipe_tag <= '0;
      for (int i = 0; i < FETCH_LAT; i++) begin
        r_pipe_pc[i] <= '0;
      end
    end else begin
      r_pipe_vld[0] <= w_issue;
      r_pipe_tag[0] <= r_epoch;
      r_pipe_pc[0]  <= r_pc;
      for (int i = 1; i < FETCH_LAT; i++) begin
        r_pipe_vld[i] <= r_pipe_vld[i-1];
        r_pipe_tag[i] <= r_pipe_tag[i-1];
        r_pipe_pc[i]  <= r_pipe_pc[i-1];
      end
    end
  end

  // FIFO pointers and occupancy; flush wins over push and pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (w_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage; contents are qualified by r_count so no reset is needed
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_pc[r_wptr]  <= r_pipe_pc[FETCH_LAT-1];
      r_fifo_ins[r_wptr] <= bus.ins_in;
    end
  end

  assign bus.pc_out    = r_pc;
  assign bus.base_out  = r_base;
  assign bus.out_valid = (r_count != '0);
  assign bus.out_pc    = r_fifo_pc[r_rptr];
  assign bus.out_ins   = r_fifo_ins[r_rptr];
  assign bus.busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a two-cycle instruction fetch model.
module tb_fetch_sequencer;

  localparam int XLEN = 32;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  logic [XLEN-1:0] r_d1;
  logic [XLEN-1:0] r_d2;

  fetch_sequencer_if #(.XLEN(XLEN)) bus ();

  fetch_sequencer #(
    .XLEN      (XLEN),
    .FETCH_LAT (2),
    .Q_DEPTH   (4),
    .START_PC  (32'h0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [XLEN-1:0] fetch_model(input logic [XLEN-1:0] pc);
    return (pc * 32'h0001_0003) ^ 32'hC0DE_0000;
  endfunction

  // Fetch datapath model: instruction for the pc presented two cycles earlier
  always @(posedge clk) begin
    r_d1 <= bus.pc_out;
    r_d2 <= r_d1;
  end
  assign bus.ins_in = fetch_model(r_d2);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_start(input logic [XLEN-1:0] base);
    bus.start    = 1'b1;
    bus.base_cfg = base;
    @(negedge clk);
    bus.start    = 1'b0;
  endtask

  // Returns number of negedges (counting the current one as 1) until out_valid
  task automatic wait_valid(output int n);
    n = 1;
    while (!bus.out_valid && n < 30) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags out_valid=%b busy=%b want 0 0", bus.out_valid, bus.busy);
    end
    checks++;
    if (bus.pc_out !== 32'h0 || bus.base_out !== 32'h0) begin
      errors++;
      $display("FAIL reset_regs pc_out=%h base_out=%h want 0 0", bus.pc_out, bus.base_out);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_stream();
    int n;
    do_reset();
    bus.out_ready = 1'b1;
    pulse_start(32'h100);
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL stream_busy got %b want 1", bus.busy);
    end
    wait_valid(n);
    checks++;
    if (n != 4) begin
      errors++;
      $display("FAIL stream_latency got %0d want 4", n);
    end
    checks++;
    if (bus.base_out !== 32'h100) begin
      errors++;
      $display("FAIL stream_base got %h want 00000100", bus.base_out);
    end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'(k) || bus.out_ins !== fetch_model(32'(k))) begin
        errors++;
        $display("FAIL stream_seq[%0d] valid=%b pc=%h ins=%h want 1 %h %h",
                 k, bus.out_valid, bus.out_pc, bus.out_ins, 32'(k), fetch_model(32'(k)));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.out_ready = 1'b0;
    pulse_start(32'h0);
    repeat (12) @(negedge clk);
    checks++;
    if (bus.pc_out !== 32'd4 || bus.out_valid !== 1'b1 || bus.out_pc !== 32'd0) begin
      errors++;
      $display("FAIL bp_stall pc_out=%h valid=%b head=%h want 4 1 0",
               bus.pc_out, bus.out_valid, bus.out_pc);
    end
    bus.out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'(k) || bus.out_ins !== fetch_model(32'(k))) begin
        errors++;
        $display("FAIL bp_resume[%0d] valid=%b pc=%h want 1 %h", k, bus.out_valid, bus.out_pc, 32'(k));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_redirect();
    int n;
    do_reset();
    bus.out_ready = 1'b1;
    pulse_start(32'h0);
    wait_valid(n);
    repeat (2) @(negedge clk);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h40;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL redir_flush out_valid=%b want 0", bus.out_valid);
    end
    @(negedge clk);
    wait_valid(n);
    checks++;
    if (n != 3) begin
      errors++;
      $display("FAIL redir_latency got %0d want 3", n);
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h40 + 32'(k) ||
          bus.out_ins !== fetch_model(32'h40 + 32'(k))) begin
        errors++;
        $display("FAIL redir_seq[%0d] valid=%b pc=%h want 1 %h",
                 k, bus.out_valid, bus.out_pc, 32'h40 + 32'(k));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_halt_drain();
    int n;
    do_reset();
    bus.out_ready = 1'b1;
    pulse_start(32'h0);
    n = 0;
    while (bus.pc_out !== 32'd6 && n < 30) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != 6 || bus.out_valid !== 1'b1 || bus.out_pc !== 32'd3) begin
      errors++;
      $display("FAIL halt_point cycles=%0d valid=%b head=%h want 6 1 3", n, bus.out_valid, bus.out_pc);
    end
    bus.halt      = 1'b1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    bus.halt = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.pc_out !== 32'd6 || bus.busy !== 1'b1 || bus.out_pc !== 32'd3) begin
      errors++;
      $display("FAIL halt_hold pc_out=%h busy=%b head=%h want 6 1 3", bus.pc_out, bus.busy, bus.out_pc);
    end
    bus.out_ready = 1'b1;
    for (int k = 3; k < 6; k++) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'(k)) begin
        errors++;
        $display("FAIL halt_drain[%0d] valid=%b pc=%h want 1 %h", k, bus.out_valid, bus.out_pc, 32'(k));
      end
      @(negedge clk);
    end
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL halt_empty out_valid=%b want 0", bus.out_valid);
    end
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.pc_out !== 32'd6) begin
      errors++;
      $display("FAIL halt_idle busy=%b pc_out=%h want 0 6", bus.busy, bus.pc_out);
    end
    pulse_start(32'h0);
    wait_valid(n);
    checks++;
    if (n != 4 || bus.out_pc !== 32'd0) begin
      errors++;
      $display("FAIL halt_restart latency=%0d pc=%h want 4 0", n, bus.out_pc);
    end
  endtask

  task automatic test_wrap();
    int n;
    do_reset();
    bus.out_ready = 1'b1;
    pulse_start(32'h0);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFFF;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    wait_valid(n);
    for (int k = 0; k < 3; k++) begin
      logic [XLEN-1:0] exp_pc;
      exp_pc = 32'hFFFF_FFFF + 32'(k);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== exp_pc || bus.out_ins !== fetch_model(exp_pc)) begin
        errors++;
        $display("FAIL wrap_seq[%0d] valid=%b pc=%h want 1 %h", k, bus.out_valid, bus.out_pc, exp_pc);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_async_reset();
    int n;
    do_reset();
    bus.out_ready = 1'b1;
    pulse_start(32'h0);
    repeat (4) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.pc_out !== 32'h0) begin
      errors++;
      $display("FAIL arst_now valid=%b busy=%b pc_out=%h want 0 0 0", bus.out_valid, bus.busy, bus.pc_out);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL arst_after valid=%b busy=%b want 0 0", bus.out_valid, bus.busy);
    end
    pulse_start(32'h200);
    wait_valid(n);
    checks++;
    if (n != 4 || bus.out_pc !== 32'd0 || bus.base_out !== 32'h200) begin
      errors++;
      $display("FAIL arst_restart latency=%0d pc=%h base=%h want 4 0 200", n, bus.out_pc, bus.base_out);
    end
  endtask

  initial begin
    checks             = 0;
    errors             = 0;
    rst                = 1'b1;
    bus.start          = 1'b0;
    bus.base_cfg       = '0;
    bus.halt           = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.out_ready      = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_halt_drain();
    test_wrap();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
